// File: rtl/contador_ajuste_bcd.sv
// One adjustable date/time field shown as 2-digit BCD.
// Press steps once, hold auto-repeats; clamps to a dynamic limit.
module contador_ajuste_bcd #(
    parameter int ID       = 6,
    parameter int MIN_VAL  = 1,
    parameter int MAX_VAL  = 31,
    parameter int DYN_MAX  = 1,
    parameter int HOLD_CYC = 50000000,
    parameter int REP_CYC  = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] contadoresH,
    input  logic       Arriba,
    input  logic       Abajo,
    input  logic       carga,
    input  logic [7:0] datos_in,
    input  logic [7:0] max_dyn,
    output logic [7:0] datos_out,
    output logic       cambio,
    output logic       activo
);

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int RW = (REP_CYC > 1) ? $clog2(REP_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_REP
    } st_t;

    function automatic logic bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    function automatic logic [6:0] bcd2bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    st_t           r_st, w_st_n;
    logic [HW-1:0] r_hcnt, w_hcnt_n;
    logic [RW-1:0] r_rcnt, w_rcnt_n;
    logic          r_dir, w_dir_n;
    logic [6:0]    r_val;
    logic          r_cambio;
    logic          r_up_q, r_dn_q;

    logic       w_up, w_dn, w_same, w_step, w_load;
    logic [6:0] w_mx_bin, w_in_bin, w_emax, w_nxt;
    logic [3:0] w_tens, w_units;

    assign activo   = (contadoresH == 4'(ID));
    assign w_up     = Arriba & ~Abajo & activo;
    assign w_dn     = Abajo & ~Arriba & activo;
    assign w_same   = r_dir ? w_up : w_dn;
    assign w_mx_bin = bcd2bin(max_dyn);
    assign w_in_bin = bcd2bin(datos_in);

    // Out-of-range or malformed limits fall back to the static maximum
    always_comb begin
        w_emax = 7'(MAX_VAL);
        if (DYN_MAX != 0 && bcd_ok(max_dyn) &&
            w_mx_bin >= 7'(MIN_VAL) && w_mx_bin < 7'(MAX_VAL))
            w_emax = w_mx_bin;
    end

    assign w_load = carga && bcd_ok(datos_in) &&
                    w_in_bin >= 7'(MIN_VAL) && w_in_bin <= w_emax;

    always_comb begin
        w_st_n   = r_st;
        w_hcnt_n = r_hcnt;
        w_rcnt_n = r_rcnt;
        w_dir_n  = r_dir;
        w_step   = 1'b0;
        unique case (r_st)
            S_IDLE: begin
                w_hcnt_n = '0;
                w_rcnt_n = '0;
                if (w_up && !r_up_q) begin
                    w_step  = 1'b1;
                    w_dir_n = 1'b1;
                    w_st_n  = S_HOLD;
                end else if (w_dn && !r_dn_q) begin
                    w_step  = 1'b1;
                    w_dir_n = 1'b0;
                    w_st_n  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!w_same) begin
                    w_st_n   = S_IDLE;
                    w_hcnt_n = '0;
                    w_rcnt_n = '0;
                end else if (r_hcnt == HW'(HOLD_CYC - 1)) begin
                    w_step   = 1'b1;
                    w_hcnt_n = '0;
                    w_rcnt_n = '0;
                    w_st_n   = S_REP;
                end else begin
                    w_hcnt_n = r_hcnt + 1'b1;
                end
            end
            S_REP: begin
                if (!w_same) begin
                    w_st_n   = S_IDLE;
                    w_hcnt_n = '0;
                    w_rcnt_n = '0;
                end else if (r_rcnt == RW'(REP_CYC - 1)) begin
                    w_step   = 1'b1;
                    w_rcnt_n = '0;
                end else begin
                    w_rcnt_n = r_rcnt + 1'b1;
                end
            end
            default: begin
                w_st_n   = S_IDLE;
                w_hcnt_n = '0;
                w_rcnt_n = '0;
            end
        endcase
        if (w_load) begin
            w_st_n   = S_IDLE;
            w_hcnt_n = '0;
            w_rcnt_n = '0;
        end
    end

    always_comb begin
        w_nxt = r_val;
        if (w_dir_n)
            w_nxt = (r_val >= w_emax) ? 7'(MIN_VAL) : r_val + 7'd1;
        else
            w_nxt = (r_val <= 7'(MIN_VAL)) ? w_emax : r_val - 7'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st   <= S_IDLE;
            r_hcnt <= '0;
            r_rcnt <= '0;
            r_dir  <= 1'b1;
        end else begin
            r_st   <= w_st_n;
            r_hcnt <= w_hcnt_n;
            r_rcnt <= w_rcnt_n;
            r_dir  <= w_dir_n;
        end
    end

    // History resets high so a button held through reset needs a release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_val    <= 7'(MIN_VAL);
            r_cambio <= 1'b0;
            r_up_q   <= 1'b1;
            r_dn_q   <= 1'b1;
        end else begin
            r_up_q   <= w_up;
            r_dn_q   <= w_dn;
            r_cambio <= 1'b0;
            if (w_load) begin
                r_val <= w_in_bin;
            end else if (r_val > w_emax) begin
                r_val    <= w_emax;
                r_cambio <= 1'b1;
            end else if (w_step) begin
                r_val    <= w_nxt;
                r_cambio <= 1'b1;
            end
        end
    end

    always_comb begin
        w_tens = 4'd0;
        for (int i = 1; i < 10; i++)
            if (r_val >= 7'(i * 10))
                w_tens = 4'(i);
        w_units = 4'(r_val - 7'(w_tens) * 7'd10);
    end

    assign datos_out = {w_tens, w_units};
    assign cambio    = r_cambio;

endmodule

// File: tb/tb_contador_ajuste_bcd.sv
// Directed bench for contador_ajuste_bcd.
// Small hold/repeat counts keep auto-repeat timing visible.
module tb_contador_ajuste_bcd;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] contadoresH;
    logic       Arriba, Abajo, carga;
    logic [7:0] datos_in, max_dyn;
    logic [7:0] datos_out;
    logic       cambio, activo;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses;

    contador_ajuste_bcd #(
        .ID(6), .MIN_VAL(1), .MAX_VAL(31), .DYN_MAX(1),
        .HOLD_CYC(8), .REP_CYC(4)
    ) dut (
        .clk(clk), .reset(reset), .contadoresH(contadoresH),
        .Arriba(Arriba), .Abajo(Abajo), .carga(carga),
        .datos_in(datos_in), .max_dyn(max_dyn),
        .datos_out(datos_out), .cambio(cambio), .activo(activo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        carga = 1'b1;
        datos_in = v;
        tick();
        carga = 1'b0;
    endtask

    initial begin
        reset = 1'b1; contadoresH = 4'd0;
        Arriba = 1'b0; Abajo = 1'b0; carga = 1'b0;
        datos_in = 8'h00; max_dyn = 8'h31;
        tick(); tick();
        check("rst_val", datos_out, 8'h01);
        check("rst_cambio", {7'd0, cambio}, 8'h00);
        check("activo_off", {7'd0, activo}, 8'h00);

        // Button held through reset release
        contadoresH = 4'd6; Arriba = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check("held_thru_rst", datos_out, 8'h01);
        check("activo_on", {7'd0, activo}, 8'h01);
        Arriba = 1'b0; tick();
        Arriba = 1'b1; tick();
        check("fresh_press", datos_out, 8'h02);
        check("fresh_cambio", {7'd0, cambio}, 8'h01);
        Arriba = 1'b0; tick();
        check("cambio_1cyc", {7'd0, cambio}, 8'h00);

        // Wrap up and down
        load(8'h31);
        check("load31", datos_out, 8'h31);
        check("load_no_cambio", {7'd0, cambio}, 8'h00);
        Arriba = 1'b1; tick();
        check("wrap_up", datos_out, 8'h01);
        check("wrap_up_cambio", {7'd0, cambio}, 8'h01);
        Arriba = 1'b0; tick();
        Abajo = 1'b1; tick();
        check("wrap_dn", datos_out, 8'h31);
        Abajo = 1'b0; tick();
        max_dyn = 8'h30; tick();
        check("clamp_30", datos_out, 8'h30);
        load(8'h01);
        Abajo = 1'b1; tick();
        check("wrap_dn_dyn", datos_out, 8'h30);
        Abajo = 1'b0; tick();

        // Auto-repeat: steps at 0, 8, 12, 16
        max_dyn = 8'h31;
        load(8'h01);
        pulses = 0;
        Arriba = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            pulses += int'(cambio);
        end
        Arriba = 1'b0; tick();
        check("repeat_val", datos_out, 8'h05);
        check("repeat_pulses", 8'(pulses), 8'd4);
        Arriba = 1'b1; Abajo = 1'b1;
        tick(); tick(); tick();
        check("both_btn", datos_out, 8'h05);
        check("both_cambio", {7'd0, cambio}, 8'h00);
        Arriba = 1'b0; Abajo = 1'b0; tick();

        // Dynamic clamp
        load(8'h30);
        max_dyn = 8'h28; tick();
        check("clamp_28", datos_out, 8'h28);
        check("clamp_cambio", {7'd0, cambio}, 8'h01);
        tick();
        check("clamp_once", {7'd0, cambio}, 8'h00);
        max_dyn = 8'h3A;
        load(8'h30);
        tick();
        check("bad_max_30", datos_out, 8'h30);
        check("bad_max_cambio", {7'd0, cambio}, 8'h00);

        // Field not selected, then deselected mid-hold
        contadoresH = 4'd5; Arriba = 1'b1;
        tick(); tick();
        check("not_sel_val", datos_out, 8'h30);
        check("not_sel_cambio", {7'd0, cambio}, 8'h00);
        Arriba = 1'b0; tick();
        contadoresH = 4'd6; Arriba = 1'b1; tick();
        check("sel_step", datos_out, 8'h31);
        tick(); tick(); tick();
        contadoresH = 4'd5;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            pulses += int'(cambio);
        end
        check("desel_val", datos_out, 8'h31);
        check("desel_pulses", 8'(pulses), 8'd0);
        Arriba = 1'b0; tick();
        contadoresH = 4'd6; tick();

        // Load rules
        load(8'h1A);
        check("bad_load", datos_out, 8'h31);
        Arriba = 1'b1; carga = 1'b1; datos_in = 8'h15;
        tick();
        carga = 1'b0;
        check("load_vs_step", datos_out, 8'h15);
        check("load_vs_cambio", {7'd0, cambio}, 8'h00);
        Arriba = 1'b0; tick();
        check("load_held", datos_out, 8'h15);

        // Reset during repeat
        Arriba = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("pre_rst_val", datos_out, 8'h17);
        reset = 1'b1; #1;
        check("rst_async", datos_out, 8'h01);
        tick();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(cambio);
        end
        check("post_rst_val", datos_out, 8'h01);
        check("post_rst_pulses", 8'(pulses), 8'd0);
        Arriba = 1'b0; tick();
        Arriba = 1'b1; tick();
        check("post_rst_step", datos_out, 8'h02);
        Arriba = 1'b0; tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/contador_ajuste_bcd.md
Name: contador_ajuste_bcd

Overview:
Parametrised successor of the single-field day-setting counter. It holds one configurable date/time field (day, month, hour, minute, year) and shows it as 2-digit BCD. The field is user-adjustable when selected by the field-select bus, with single-step on press and auto-repeat on hold. It supports a dynamic upper limit (for example, days-in-month) with clamping, and loads from RTC readback. One instance per field sits between the button/FSM controller and the RTC write-back/display path.

Parameters:
ID, 6, value of contadoresH that selects this field for editing
MIN_VAL, 1, lowest field value (decimal); 0 for hours/minutes
MAX_VAL, 31, highest field value (decimal); MIN_VAL < MAX_VAL <= 99
DYN_MAX, 1, 1 = effective max taken from max_dyn; 0 = MAX_VAL always
HOLD_CYC, 50000000, cycles a button must be held before auto-repeat starts (>= 2)
REP_CYC, 12500000, cycles between auto-repeat steps (>= 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
contadoresH  in  4  field-select code; the field is editable when it equals ID
Arriba  in  1  increment button, synchronous debounced level
Abajo  in  1  decrement button, synchronous debounced level
carga  in  1  one-cycle load strobe
datos_in  in  8  BCD value loaded on carga
max_dyn  in  8  BCD dynamic upper limit (used when DYN_MAX=1)
datos_out  out  8  {tens, units} BCD of the current value
cambio  out  1  one-cycle pulse, aligned with datos_out, on every value change except load/reset
activo  out  1  combinational: contadoresH == ID

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is asynchronous and active-high.
- Reset state:
  - value = MIN_VAL, so datos_out = BCD(MIN_VAL).
  - cambio = 0; FSM = IDLE; hold/repeat counters = 0.
  - Button-history registers reset to 1, so a button already held through reset release does not step until it is released and pressed again.
- Storage: value is a 7-bit binary register. datos_out is a combinational binary-to-BCD conversion of the register, so it updates the cycle after the register is written.
- Effective max (emax):
  - DYN_MAX=0: emax = MAX_VAL.
  - DYN_MAX=1: emax = min(bin(max_dyn), MAX_VAL).
  - If max_dyn has a nibble > 9, or bin(max_dyn) < MIN_VAL, then emax = MAX_VAL.
- Step rules:
  - Up: value >= emax → MIN_VAL, else value+1.
  - Down: value <= MIN_VAL → emax, else value-1.
- Button qualifier: "btn" = exactly one of Arriba/Abajo high AND activo. Both high counts as no button.
- FSM:
  - IDLE: on a rising edge of a qualified button, take 1 step immediately, clear the hold counter, go to HOLD.
  - HOLD: the hold counter increments each cycle while the same button stays qualified.
    - When the counter reaches HOLD_CYC-1: take 1 step, clear the counter, go to REPEAT.
    - On release, direction change, both buttons pressed, or activo dropping: go to IDLE and clear counters, with no step.
  - REPEAT: take 1 step every REP_CYC cycles while the button stays qualified. Exit conditions are the same as HOLD.
  - A direction change always passes through IDLE; the new button is seen as a fresh edge only after a released cycle.
- Clamp: if value > emax while no load or step is in progress (for example, the month changes to February), value = emax on the next cycle and cambio pulses.
- Priority, same cycle: reset > carga > clamp > step.
- Load (carga):
  - Accepted regardless of activo.
  - Loads bin(datos_in) only if both nibbles are <= 9 and MIN_VAL <= value <= emax; otherwise carga is ignored.
  - An accepted load cancels any step in the same cycle, sends the FSM to IDLE, and does not pulse cambio.
- cambio: registered; high for exactly one cycle when a step or clamp writes the value.
- Reset mid-hold: the FSM aborts immediately and the value returns to MIN_VAL.
- Counter widths: $clog2 of HOLD_CYC and REP_CYC; no overflow is possible.

Test Plan:
Bench parameters: ID=6, MIN_VAL=1, MAX_VAL=31, DYN_MAX=1, HOLD_CYC=8, REP_CYC=4, max_dyn=8'h31 unless stated.
1. Reset asserted then released → datos_out=8'h01, cambio=0, activo=0 with contadoresH=0. Hold Arriba high through reset release → no step until it is released and pressed again.
2. carga with datos_in=8'h31, then contadoresH=6, Arriba high for 1 cycle → datos_out=8'h01 and one cambio pulse. Abajo for 1 cycle → 8'h31. Set max_dyn=8'h30, Abajo from 01 → 8'h30.
3. From 8'h01, hold Arriba for 20 cycles → steps on cycles 0, 8, 12, 16, final value 8'h05, exactly 4 cambio pulses. Arriba and Abajo both high → no step.
4. Value 8'h30, max_dyn changes to 8'h28 → datos_out=8'h28 next cycle with one cambio pulse. max_dyn=8'h3A (invalid) → emax=31, no clamp.
5. contadoresH=5 and Arriba pressed → no change, no cambio. contadoresH switched away in the middle of a hold → FSM goes to IDLE and stepping stops.
6. carga with datos_in=8'h1A → ignored. carga with 8'h15 in the same cycle as an Arriba edge → 8'h15, no cambio. Reset during REPEAT → 8'h01 with counters cleared.
